// File: rtl/mul_iter_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mul_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_iter_state_e;

    // Digit counter width: enough bits to count 0..N-1, never less than one bit.
    function automatic int mul_iter_cnt_width(input int width_p, input int digit_p);
        int n;
        n = width_p / digit_p;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_iter_digit_row.sv
// One partial-product row: adds |a| times a multiplier digit onto the upper accumulator half.
module mul_iter_digit_row #(
    parameter int width_p = 128,
    parameter int digit_p = 8
) (
    input  logic [width_p-1:0]         hi_i,
    input  logic [width_p-1:0]         a_i,
    input  logic [digit_p-1:0]         digit_i,
    output logic [width_p+digit_p-1:0] sum_o
);

    localparam int sum_width_lp = width_p + digit_p;

    logic [sum_width_lp-1:0] hi_ext;
    logic [sum_width_lp-1:0] a_ext;
    logic [sum_width_lp-1:0] digit_ext;

    // (2^w-1) + (2^w-1)(2^d-1) < 2^(w+d), so the row sum cannot overflow.
    assign hi_ext    = {{digit_p{1'b0}}, hi_i};
    assign a_ext     = {{digit_p{1'b0}}, a_i};
    assign digit_ext = {{width_p{1'b0}}, digit_i};
    assign sum_o     = hi_ext + a_ext * digit_ext;

endmodule

// File: rtl/mul_iter.sv
// Iterative signed/unsigned multiplier retiring digit_p multiplier bits per cycle,
// with valid/ready operand intake and valid/yumi product handoff.
module mul_iter
    import mul_iter_pkg::*;
#(
    parameter int width_p = 128,
    parameter int digit_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     a_i,
    input  logic [width_p-1:0]     b_i,
    input  logic                   signed_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [2*width_p-1:0]   c_o,
    input  logic                   yumi_i
);

    if (width_p < 2 || digit_p < 1 || digit_p > width_p || (width_p % digit_p) != 0) begin : g_bad_params
        $error("mul_iter: illegal width_p/digit_p combination");
    end

    localparam int n_lp   = width_p / digit_p;
    localparam int cnt_lp = mul_iter_cnt_width(width_p, digit_p);
    localparam logic [cnt_lp-1:0] cnt_last_lp = cnt_lp'(n_lp - 1);

    mul_iter_state_e           state_r;
    logic [width_p-1:0]        a_mag_r;
    logic [width_p-1:0]        bsh_r;
    logic [2*width_p-1:0]      acc_r;
    logic [cnt_lp-1:0]         cnt_r;
    logic                      neg_r;

    logic [width_p-1:0]        a_abs;
    logic [width_p-1:0]        b_abs;
    logic [width_p+digit_p-1:0] sum;
    logic [2*width_p-1:0]      acc_next;
    logic [width_p-1:0]        bsh_next;

    // Magnitudes fit unsigned even for the most negative operand.
    assign a_abs = (signed_i & a_i[width_p-1]) ? (~a_i + width_p'(1)) : a_i;
    assign b_abs = (signed_i & b_i[width_p-1]) ? (~b_i + width_p'(1)) : b_i;

    mul_iter_digit_row #(
        .width_p (width_p),
        .digit_p (digit_p)
    ) u_row (
        .hi_i    (acc_r[2*width_p-1:width_p]),
        .a_i     (a_mag_r),
        .digit_i (bsh_r[digit_p-1:0]),
        .sum_o   (sum)
    );

    // With a single digit the whole product lands in one step and nothing is left to shift.
    if (digit_p == width_p) begin : g_single
        assign acc_next = sum;
        assign bsh_next = '0;
    end else begin : g_multi
        assign acc_next = {sum, acc_r[width_p-1:digit_p]};
        assign bsh_next = {{digit_p{1'b0}}, bsh_r[width_p-1:digit_p]};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            a_mag_r <= '0;
            bsh_r   <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            neg_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (v_i) begin
                        a_mag_r <= a_abs;
                        bsh_r   <= b_abs;
                        neg_r   <= signed_i & (a_i[width_p-1] ^ b_i[width_p-1]);
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    acc_r <= acc_next;
                    bsh_r <= bsh_next;
                    cnt_r <= cnt_r + cnt_lp'(1);
                    if (cnt_r == cnt_last_lp) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_r == IDLE) & ~reset_i;
    assign v_o     = (state_r == DONE);
    assign c_o     = neg_r ? (~acc_r + (2*width_p)'(1)) : acc_r;

endmodule

// File: tb/tb_mul_iter.sv
// Directed and randomised checks of mul_iter at 8x2 plus a 128-bit digit sweep.
module tb_mul_iter;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] c;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        signed_i;
    logic        ready_o;
    logic        v_o;
    logic [15:0] c_o;
    logic        yumi_i;

    logic         wv;
    logic         ws;
    logic [127:0] wa;
    logic [127:0] wb;
    logic [2:0]   wyumi;
    logic [2:0]   wready;
    logic [2:0]   wvo;
    logic [255:0] wc0;
    logic [255:0] wc1;
    logic [255:0] wc2;

    int checks = 0;
    int errors = 0;

    vec_t        vecs[12];
    logic [15:0] expq[$];

    always #5 clk = ~clk;

    mul_iter #(.width_p(8), .digit_p(2)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .a_i(a_i), .b_i(b_i),
        .signed_i(signed_i), .ready_o(ready_o), .v_o(v_o), .c_o(c_o), .yumi_i(yumi_i)
    );

    mul_iter #(.width_p(128), .digit_p(1)) dut_w1 (
        .clk_i(clk), .reset_i(reset_i), .v_i(wv), .a_i(wa), .b_i(wb),
        .signed_i(ws), .ready_o(wready[0]), .v_o(wvo[0]), .c_o(wc0), .yumi_i(wyumi[0])
    );

    mul_iter #(.width_p(128), .digit_p(8)) dut_w8 (
        .clk_i(clk), .reset_i(reset_i), .v_i(wv), .a_i(wa), .b_i(wb),
        .signed_i(ws), .ready_o(wready[1]), .v_o(wvo[1]), .c_o(wc1), .yumi_i(wyumi[1])
    );

    mul_iter #(.width_p(128), .digit_p(128)) dut_w128 (
        .clk_i(clk), .reset_i(reset_i), .v_i(wv), .a_i(wa), .b_i(wb),
        .signed_i(ws), .ready_o(wready[2]), .v_o(wvo[2]), .c_o(wc2), .yumi_i(wyumi[2])
    );

    // The bench itself must never take a product that is not on offer.
    always @(posedge clk) begin
        if (yumi_i && !v_o) begin
            errors++;
            $display("[TB] FAIL yumi protocol: yumi_i=1 while v_o=0");
        end
        if ((wyumi & ~wvo) != 3'b000) begin
            errors++;
            $display("[TB] FAIL wide yumi protocol: yumi=%b v_o=%b", wyumi, wvo);
        end
    end

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = {{8{s & a[7]}}, a};
        eb = {{8{s & b[7]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [255:0] model_wide(input logic [127:0] a, input logic [127:0] b, input logic s);
        logic [255:0] ea;
        logic [255:0] eb;
        ea = {{128{s & a[127]}}, a};
        eb = {{128{s & b[127]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [255:0] wide_c(input int i);
        case (i)
            0:       return wc0;
            1:       return wc1;
            default: return wc2;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one 8-bit transaction from a negedge; returns the product and accept-to-v_o latency.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 output logic [15:0] c, output int lat);
        int guard;
        guard = 0;
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) checkOutput("ready before accept", 256'(ready_o), 256'(1));
        a_i = a; b_i = b; signed_i = s; v_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0; a_i = 8'($urandom); b_i = 8'($urandom); signed_i = ~s;
        lat = 0;
        while (!v_o && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        c = c_o;
        if (v_o) begin
            yumi_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            yumi_i = 1'b0;
        end
    endtask

    // Same operands into all three wide instances; each is consumed as soon as it finishes.
    task automatic runWide(input logic [127:0] a, input logic [127:0] b, input logic s);
        int lat;
        int guard;
        int lats[3];
        logic [2:0] done;
        logic [255:0] expected;
        expected = model_wide(a, b, s);
        guard = 0;
        while (wready != 3'b111 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        wa = a; wb = b; ws = s; wv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wv = 1'b0; wa = {4{$urandom}}; wb = {4{$urandom}}; ws = ~s;
        lat = 0;
        done = 3'b000;
        lats = '{-1, -1, -1};
        while (done != 3'b111 && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            wyumi = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (!done[i] && wvo[i]) begin
                    done[i]  = 1'b1;
                    lats[i]  = lat;
                    wyumi[i] = 1'b1;
                    checkOutput($sformatf("wide%0d product", i), wide_c(i), expected);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        wyumi = 3'b000;
        checkOutput("wide digit1 latency", 256'(lats[0]), 256'(128));
        checkOutput("wide digit8 latency", 256'(lats[1]), 256'(16));
        checkOutput("wide digit128 latency", 256'(lats[2]), 256'(1));
    endtask

    initial begin
        logic [15:0] c;
        int          lat;
        int          accepted;
        int          consumed;
        int          delay;
        int          cyc;
        logic        just_acc;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
        vecs[3]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
        vecs[4]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vecs[5]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[7]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
        vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[9]  = '{8'h00, 8'hAB, 1'b1, 16'h0000};
        vecs[10] = '{8'h0C, 8'hF6, 1'b0, 16'h0B88};
        vecs[11] = '{8'hF6, 8'h0C, 1'b1, 16'hFF88};

        reset_i = 1'b1; v_i = 1'b0; a_i = '0; b_i = '0; signed_i = 1'b0; yumi_i = 1'b0;
        wv = 1'b0; ws = 1'b0; wa = '0; wb = '0; wyumi = 3'b000;

        // Power-on reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ready_o", 256'(ready_o), 256'(0));
        checkOutput("reset v_o", 256'(v_o), 256'(0));
        checkOutput("reset c_o", 256'(c_o), 256'(0));
        checkOutput("reset wide ready", 256'(wready), 256'(0));
        reset_i = 1'b0;
        #1;
        checkOutput("ready after reset", 256'(ready_o), 256'(1));
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, c, lat);
            checkOutput($sformatf("vec%0d product", i), 256'(c), 256'(vecs[i].c));
            checkOutput($sformatf("vec%0d latency", i), 256'(lat), 256'(4));
        end

        // Reset while BUSY aborts the transaction.
        a_i = 8'hAB; b_i = 8'hCD; signed_i = 1'b1; v_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("ready during reset", 256'(ready_o), 256'(0));
        reset_i = 1'b0;
        #1;
        checkOutput("abort v_o", 256'(v_o), 256'(0));
        checkOutput("abort ready_o", 256'(ready_o), 256'(1));
        checkOutput("abort c_o", 256'(c_o), 256'(0));
        @(negedge clk);
        applyStimulus(8'h03, 8'h05, 1'b0, c, lat);
        checkOutput("post-abort product", 256'(c), 256'(15));
        checkOutput("post-abort latency", 256'(lat), 256'(4));

        // Backpressure: DONE holds while v_i pulses are ignored.
        a_i = 8'h12; b_i = 8'h34; signed_i = 1'b0; v_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        cyc = 0;
        while (!v_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 10; k++) begin
            v_i = k[0]; a_i = 8'($urandom); b_i = 8'($urandom); signed_i = 1'($urandom);
            @(negedge clk);
            checkOutput($sformatf("stall%0d c_o", k), 256'(c_o), 256'(16'h03A8));
            checkOutput($sformatf("stall%0d v_o/ready_o", k), 256'({v_o, ready_o}), 256'(2'b10));
        end
        v_i = 1'b0;
        yumi_i = v_o;
        @(posedge clk);
        @(negedge clk);
        yumi_i = 1'b0;
        checkOutput("after yumi v_o/ready_o", 256'({v_o, ready_o}), 256'(2'b01));
        applyStimulus(8'h02, 8'h03, 1'b0, c, lat);
        checkOutput("after stall product", 256'(c), 256'(6));

        // Back-to-back with v_i high and random consumer delays.
        accepted = 0; consumed = 0; cyc = 0; just_acc = 1'b0;
        delay = $urandom_range(0, 3);
        a_i = 8'($urandom); b_i = 8'($urandom); signed_i = 1'($urandom); v_i = 1'b1;
        while (consumed < 100 && cyc < 5000) begin
            if (just_acc) begin
                just_acc = 1'b0;
                if (accepted < 100) begin
                    a_i = 8'($urandom); b_i = 8'($urandom); signed_i = 1'($urandom);
                end else begin
                    v_i = 1'b0;
                end
            end
            if (ready_o && v_i) begin
                expq.push_back(model8(a_i, b_i, signed_i));
                accepted++;
                just_acc = 1'b1;
            end
            @(negedge clk);
            cyc++;
            yumi_i = 1'b0;
            if (v_o) begin
                if (delay > 0) begin
                    delay--;
                end else begin
                    if (expq.size() == 0) begin
                        checkOutput("b2b unexpected product", 256'(expq.size()), 256'(1));
                    end else begin
                        checkOutput($sformatf("b2b product %0d", consumed), 256'(c_o), 256'(expq.pop_front()));
                    end
                    consumed++;
                    yumi_i = 1'b1;
                    delay = $urandom_range(0, 3);
                end
            end
        end
        @(negedge clk);
        yumi_i = 1'b0;
        v_i = 1'b0;
        checkOutput("b2b consumed", 256'(consumed), 256'(100));
        checkOutput("b2b accepted", 256'(accepted), 256'(100));
        checkOutput("b2b leftover", 256'(expq.size()), 256'(0));
        repeat (2) @(negedge clk);

        // 128-bit sweep over digit sizes 1, 8 and 128.
        runWide({4{$urandom}}, {4{$urandom}}, 1'b0);
        runWide({4{$urandom}}, {4{$urandom}}, 1'b1);
        runWide({1'b1, 127'b0}, {1'b1, 127'b0}, 1'b1);
        runWide({128{1'b1}}, {128{1'b1}}, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
